// File: rtl/uart_paket.sv
// Shared definitions for the parametrised UART transmitter: FSM states,
// data-width and parity encodings, line levels and a data-mask helper.
package uart_paket;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic [2:0] {
    BOSTA,
    BASLA,
    VERI,
    PARITE,
    DUR
  } durum_t;

  typedef enum logic [1:0] {
    VERI_5 = 2'b00,
    VERI_6 = 2'b01,
    VERI_7 = 2'b10,
    VERI_8 = 2'b11
  } veri_bit_t;

  typedef enum logic [1:0] {
    PAR_YOK   = 2'b00,
    PAR_CIFT  = 2'b01,
    PAR_TEK   = 2'b10,
    PAR_YOK_2 = 2'b11
  } parite_t;

  // Mask that keeps only the data bits actually sent for a given width code.
  function automatic logic [7:0] veri_maske(input logic [1:0] veri_bit);
    logic [7:0] maske;
    unique case (veri_bit)
      VERI_5:  maske = 8'h1F;
      VERI_6:  maske = 8'h3F;
      VERI_7:  maske = 8'h7F;
      default: maske = 8'hFF;
    endcase
    return maske;
  endfunction

endpackage

// File: rtl/uart_verici_fifo.sv
// Synchronous TX FIFO with occupancy count and show-ahead read data.
module uart_verici_fifo #(
  parameter  int DERINLIK = 8,
  parameter  int W        = 8,
  localparam int ADR_W    = $clog2(DERINLIK),
  localparam int SAYAC_W  = ADR_W + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [W-1:0]       veri_i,
  output logic [W-1:0]       veri_o,
  output logic [SAYAC_W-1:0] sayi_o
);

  logic [W-1:0]       bellek [DERINLIK];
  logic [ADR_W-1:0]   yaz_ptr;
  logic [ADR_W-1:0]   oku_ptr;
  logic [SAYAC_W-1:0] sayi;
  logic               yaz;
  logic               oku;

  assign yaz = push_i && (sayi != SAYAC_W'(DERINLIK));
  assign oku = pop_i && (sayi != '0);

  // NOTE: storage has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (yaz) bellek[yaz_ptr] <= veri_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayi    <= '0;
    end else begin
      if (yaz) yaz_ptr <= yaz_ptr + ADR_W'(1);
      if (oku) oku_ptr <= oku_ptr + ADR_W'(1);
      unique case ({yaz, oku})
        2'b10:   sayi <= sayi + SAYAC_W'(1);
        2'b01:   sayi <= sayi - SAYAC_W'(1);
        default: sayi <= sayi;
      endcase
    end
  end

  assign veri_o = bellek[oku_ptr];
  assign sayi_o = sayi;

endmodule

// File: rtl/uart_verici_param.sv
// Parametrised UART transmitter (5-8 data bits, none/even/odd parity, 1/2 stop).
// Define UART_VERICI_FIFO_EN to buffer words in a FIFO instead of one holding register.
module uart_verici_param
  import uart_paket::*;
#(
  parameter int BAUD_W        = 16,
  parameter int FIFO_DERINLIK = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           tx_en_i,
  input  logic                           veri_gecerli_i,
  output logic                           veri_hazir_o,
  input  logic [7:0]                     veri_i,
  input  logic [BAUD_W-1:0]              baud_div_i,
  input  logic [1:0]                     veri_bit_i,
  input  logic [1:0]                     parite_i,
  input  logic                           dur_bit_i,
  output logic                           tx_o,
  output logic                           mesgul_o,
  output logic                           bitti_o,
  output logic [$clog2(FIFO_DERINLIK):0] doluluk_o
);

  localparam int SAYAC_W = $clog2(FIFO_DERINLIK) + 1;

  logic               push;
  logic               pop;
  logic               tampon_dolu_var;
  logic [7:0]         tampon_veri;
  logic [SAYAC_W-1:0] sayi;

  assign push = veri_gecerli_i && veri_hazir_o;

`ifdef UART_VERICI_FIFO_EN
  uart_verici_fifo #(
    .DERINLIK (FIFO_DERINLIK),
    .W        (8)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .pop_i  (pop),
    .veri_i (veri_i),
    .veri_o (tampon_veri),
    .sayi_o (sayi)
  );

  assign veri_hazir_o = (sayi != SAYAC_W'(FIFO_DERINLIK));
`else
  logic       tutucu_dolu;
  logic [7:0] tutucu;

  // Holding register frees as soon as its word moves into the shift register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tutucu_dolu <= 1'b0;
      tutucu      <= '0;
    end else if (push) begin
      tutucu_dolu <= 1'b1;
      tutucu      <= veri_i;
    end else if (pop) begin
      tutucu_dolu <= 1'b0;
    end
  end

  assign tampon_veri  = tutucu;
  assign sayi         = SAYAC_W'(tutucu_dolu);
  assign veri_hazir_o = !tutucu_dolu;
`endif

  assign tampon_dolu_var = (sayi != '0);
  assign doluluk_o       = sayi;

  durum_t              durum_q, durum_d;
  logic [BAUD_W-1:0]   sayac_q;
  logic [BAUD_W-1:0]   div_m1_q;
  logic [2:0]          idx_q;
  logic [2:0]          son_veri_q;
  logic [7:0]          kaydirma_q;
  logic                par_en_q;
  logic                par_bit_q;
  logic                dur2_q;
  logic                tx_q, tx_d;
  logic                bit_son;
  logic                basla_ok;
  logic                bitti;

  assign bit_son  = (durum_q != BOSTA) && (sayac_q == div_m1_q);
  assign basla_ok = tx_en_i && tampon_dolu_var;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) durum_q <= BOSTA;
    else       durum_q <= durum_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    durum_d = durum_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    bitti   = 1'b0;
    unique case (durum_q)
      BOSTA: begin
        if (basla_ok) begin
          durum_d = BASLA;
          tx_d    = LOW;
          pop     = 1'b1;
        end else begin
          tx_d = HIGH;
        end
      end
      BASLA: begin
        if (bit_son) begin
          durum_d = VERI;
          tx_d    = kaydirma_q[0];
        end
      end
      VERI: begin
        if (bit_son) begin
          if (idx_q == son_veri_q) begin
            durum_d = par_en_q ? PARITE : DUR;
            tx_d    = par_en_q ? par_bit_q : HIGH;
          end else begin
            tx_d = kaydirma_q[1];
          end
        end
      end
      PARITE: begin
        if (bit_son) begin
          durum_d = DUR;
          tx_d    = HIGH;
        end
      end
      DUR: begin
        if (bit_son && (idx_q == {2'b00, dur2_q})) begin
          bitti = 1'b1;
          // Back-to-back frames start straight from the last stop clock.
          if (basla_ok) begin
            durum_d = BASLA;
            tx_d    = LOW;
            pop     = 1'b1;
          end else begin
            durum_d = BOSTA;
            tx_d    = HIGH;
          end
        end
      end
      default: begin
        durum_d = BOSTA;
        tx_d    = HIGH;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_q       <= HIGH;
      sayac_q    <= '0;
      div_m1_q   <= '0;
      idx_q      <= '0;
      son_veri_q <= '0;
      kaydirma_q <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      dur2_q     <= 1'b0;
    end else begin
      tx_q <= tx_d;
      if (pop) begin
        // Frame format is frozen here; later input changes wait for the next frame.
        sayac_q    <= '0;
        idx_q      <= '0;
        kaydirma_q <= tampon_veri;
        div_m1_q   <= (baud_div_i == '0) ? '0 : baud_div_i - BAUD_W'(1);
        son_veri_q <= 3'd4 + {1'b0, veri_bit_i};
        par_en_q   <= (parite_i == PAR_CIFT) || (parite_i == PAR_TEK);
        par_bit_q  <= (^(tampon_veri & veri_maske(veri_bit_i))) ^ (parite_i == PAR_TEK);
        dur2_q     <= dur_bit_i;
      end else if (bit_son) begin
        sayac_q <= '0;
        idx_q   <= (durum_d != durum_q) ? 3'd0 : idx_q + 3'd1;
        if (durum_q == VERI) kaydirma_q <= kaydirma_q >> 1;
      end else if (durum_q != BOSTA) begin
        sayac_q <= sayac_q + BAUD_W'(1);
      end
    end
  end

  assign tx_o     = tx_q;
  assign mesgul_o = (durum_q != BOSTA);
  assign bitti_o  = bitti;

endmodule

// File: tb/tb_uart_verici_param.sv
// Directed self-checking bench for uart_verici_param; works with and without
// UART_VERICI_FIFO_EN (FIFO_DERINLIK = 4).
module tb_uart_verici_param;

  localparam int BAUD_W   = 16;
  localparam int DERINLIK = 4;
`ifdef UART_VERICI_FIFO_EN
  localparam int KAP = 4;
`else
  localparam int KAP = 1;
`endif

  logic              clk;
  logic              rst;
  logic              tx_en;
  logic              veri_gecerli;
  logic              veri_hazir;
  logic [7:0]        veri;
  logic [BAUD_W-1:0] baud_div;
  logic [1:0]        veri_bit;
  logic [1:0]        parite;
  logic              dur_bit;
  logic              tx;
  logic              mesgul;
  logic              bitti;
  logic [2:0]        doluluk;

  int checks = 0;
  int errors = 0;

  uart_verici_param #(
    .BAUD_W        (BAUD_W),
    .FIFO_DERINLIK (DERINLIK)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tx_en_i        (tx_en),
    .veri_gecerli_i (veri_gecerli),
    .veri_hazir_o   (veri_hazir),
    .veri_i         (veri),
    .baud_div_i     (baud_div),
    .veri_bit_i     (veri_bit),
    .parite_i       (parite),
    .dur_bit_i      (dur_bit),
    .tx_o           (tx),
    .mesgul_o       (mesgul),
    .bitti_o        (bitti),
    .doluluk_o      (doluluk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one word and returns how many edges passed until it was taken.
  task automatic push_word(input logic [7:0] w, output int n);
    n = 0;
    veri_gecerli = 1'b1;
    veri         = w;
    for (int t = 0; t < 200 && !veri_hazir; t++) begin
      tick();
      n++;
    end
    check("push_ready", veri_hazir, 1);
    tick();
    n++;
    veri_gecerli = 1'b0;
  endtask

  // Checks one frame clock by clock; bits[0] is the first bit on the line.
  task automatic check_frame(input string tag, input logic [11:0] bits, input int n,
                             input int div, input int start);
    for (int c = start; c < n * div; c++) begin
      tick();
      check({tag, "_tx"},   tx,     bits[c / div]);
      check({tag, "_busy"}, mesgul, 1);
      check({tag, "_done"}, bitti,  (c == n * div - 1));
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      tick();
      check({tag, "_tx"},   tx,     1);
      check({tag, "_busy"}, mesgul, 0);
      check({tag, "_done"}, bitti,  0);
    end
  endtask

  function automatic logic [11:0] f8n1(input logic [7:0] w);
    return {3'b001, w, 1'b0};
  endfunction

  initial begin
    int n;
    int start;

    rst          = 1'b1;
    tx_en        = 1'b0;
    veri_gecerli = 1'b0;
    veri         = 8'h00;
    baud_div     = 16'd4;
    veri_bit     = 2'b11;
    parite       = 2'b00;
    dur_bit      = 1'b0;

    // Reset state
    #22;
    check("rst_tx",      tx,         1);
    check("rst_ready",   veri_hazir, 1);
    check("rst_busy",    mesgul,     0);
    check("rst_done",    bitti,      0);
    check("rst_level",   doluluk,    0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Empty buffer with enable high stays idle
    tx_en = 1'b1;
    idle_check("empty", 3);

    // 0xA5, div 4, 8N1: 0,1,0,1,0,0,1,0,1,1
    push_word(8'hA5, n);
    check("a5_prestart_tx", tx,      1);
    check("a5_level",       doluluk, 1);
    check_frame("a5", 12'b00_1101001010, 10, 4, 0);
    idle_check("a5_idle", 2);

    // 0x1F, div 3, 5 bits, odd parity, 2 stop: 0,1,1,1,1,1,0,1,1
    baud_div = 16'd3;
    veri_bit = 2'b00;
    parite   = 2'b10;
    dur_bit  = 1'b1;
    push_word(8'h1F, n);
    check_frame("1f", 12'b000_110111110, 9, 3, 0);
    idle_check("1f_idle", 2);

    // 0xBC, div 2, 7 bits (bit 7 ignored), even parity, 1 stop: 0,0,0,1,1,1,1,0,0,1
    baud_div = 16'd2;
    veri_bit = 2'b10;
    parite   = 2'b01;
    dur_bit  = 1'b0;
    push_word(8'hBC, n);
    check_frame("bc", 12'b00_1001111000, 10, 2, 0);
    idle_check("bc_idle", 2);

    // div 0 behaves as div 1: 10-clock frame for 0x00
    baud_div = 16'd0;
    veri_bit = 2'b11;
    parite   = 2'b00;
    push_word(8'h00, n);
    check_frame("div0", 12'b00_1000000000, 10, 1, 0);
    idle_check("div0_idle", 2);

    // Fill the buffer with transmission disabled
    baud_div = 16'd2;
    tx_en    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      veri_gecerli = 1'b1;
      veri         = 8'h30 + 8'(i);
      check("fill_ready", veri_hazir, (i < KAP));
      tick();
    end
    veri_gecerli = 1'b0;
    check("fill_level", doluluk,    KAP);
    check("fill_full",  veri_hazir, 0);
    idle_check("fill_hold", 2);
    tx_en = 1'b1;
    for (int i = 0; i < KAP; i++) begin
      check_frame("b2b", f8n1(8'h30 + 8'(i)), 10, 2, 0);
    end
    idle_check("b2b_idle", 2);
    check("b2b_level", doluluk, 0);

    // Reset in the middle of VERI with a second word queued
    baud_div = 16'd4;
    push_word(8'h55, n);
    push_word(8'h66, n);
    for (int k = 0; k < 6; k++) tick();
    check("mid_busy", mesgul, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_tx",    tx,         1);
    check("mid_rst_busy",  mesgul,     0);
    check("mid_rst_level", doluluk,    0);
    check("mid_rst_ready", veri_hazir, 1);
    @(negedge clk);
    rst = 1'b0;
    idle_check("mid_rst_idle", 3);
    push_word(8'h0F, n);
    check_frame("post_rst", f8n1(8'h0F), 10, 4, 0);
    idle_check("post_rst_idle", 2);

    // Drop enable during VERI with a word queued; format changes must not affect this frame
    baud_div = 16'd2;
    push_word(8'hC3, n);
    push_word(8'h5A, n);
    start = n;
    for (int k = 0; k < 3; k++) tick();
    start += 3;
    tx_en    = 1'b0;
    baud_div = 16'd9;
    veri_bit = 2'b00;
    check_frame("drop", f8n1(8'hC3), 10, 2, start);
    idle_check("drop_idle", 6);
    check("drop_level", doluluk, 1);
    baud_div = 16'd2;
    veri_bit = 2'b11;
    tx_en    = 1'b1;
    check_frame("resume", f8n1(8'h5A), 10, 2, 0);
    idle_check("resume_idle", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_verici_param.md
# uart_verici_param

Parametrised UART transmitter; successor of the fixed 8N1 transmitter in the peripheral (cevre_birimleri) subsystem. Accepts bytes over a valid/ready handshake, buffers them, and serialises frames with runtime-selectable data width (5–8), parity (none/even/odd) and stop bits (1/2). Each bit is held for exactly `baud_div_i` clocks, start bit included. Sits between the bus-side UART register block and the `tx` pad.

## Interface
Parameters:
- `BAUD_W`, 16 — width of the baud divisor.
- `FIFO_DERINLIK`, 8 — TX FIFO depth; power of two, ≥2; used only with `UART_VERICI_FIFO_EN`.

Ports:
- `clk_i` in 1 — the single clock.
- `rst_i` in 1 — reset; asynchronous, active-high.
- `tx_en_i` in 1 — transmit enable; gates frame starts only.
- `veri_gecerli_i` in 1 — input word valid.
- `veri_hazir_o` out 1 — input word ready; a transfer is `veri_gecerli_i && veri_hazir_o` at a rising edge.
- `veri_i` in 8 — data; bits above the selected width are ignored.
- `baud_div_i` in BAUD_W — clocks per bit; 0 is treated as 1.
- `veri_bit_i` in 2 — 00 = 5, 01 = 6, 10 = 7, 11 = 8 data bits.
- `parite_i` in 2 — 00 = none, 01 = even, 10 = odd, 11 = none.
- `dur_bit_i` in 1 — 0 = one stop bit, 1 = two stop bits.
- `tx_o` out 1 — serial line; registered; idle high.
- `mesgul_o` out 1 — high while a frame is being shifted.
- `bitti_o` out 1 — one-cycle pulse in the last clock of each frame.
- `doluluk_o` out clog2(FIFO_DERINLIK)+1 — buffered word count.

## Operation
- FSM states: BOSTA, BASLA, VERI, PARITE, DUR.
- BOSTA → BASLA when `tx_en_i` is high and a word is buffered. Transition actions:
  - pop the word into the shift register;
  - latch `baud_div_i`, `veri_bit_i`, `parite_i` and `dur_bit_i` for the whole frame.
- BASLA: `tx_o` = 0 for one bit period, then → VERI.
- VERI: shift out LSB first for D bits.
  - If parity is enabled, → PARITE; otherwise → DUR.
- PARITE: send the XOR of the D used bits (even), or its inverse (odd).
- DUR: `tx_o` = 1 for 1 or 2 bit periods.
  - At the end of DUR, if `tx_en_i` is high and a word is buffered → BASLA directly, with no idle gap. Otherwise → BOSTA.
- Bit timer:
  - counts 0 … div−1, where div = max(latched divisor, 1);
  - the bit advances when the count reaches div−1;
  - the timer restarts at 0 on entry to BASLA.
- Frame length: div × (1 + D + P + S) clocks.
- `tx_en_i` deasserted mid-frame: the current frame completes; no new frame starts.
- Changing `baud_div_i` or the format inputs mid-frame has no effect until the next frame start.
- `mesgul_o` is high in BASLA, VERI, PARITE and DUR.
- `bitti_o` is high in the last clock of DUR.

## Timing
- Reset values (async, immediate, including mid-frame):
  - `tx_o` = 1; `veri_hazir_o` = 1; `mesgul_o` = 0; `bitti_o` = 0; `doluluk_o` = 0;
  - FSM in BOSTA; buffer empty.
- Latency: word accepted at edge N into an idle, enabled block → `tx_o` low from edge N+1.
- `veri_hazir_o` is derived from the registered count. When full it is 0, even in a cycle that pops.
- Simultaneous push and pop when not full: both happen; count unchanged.
- Empty buffer with `tx_en_i` high: FSM stays in BOSTA; `tx_o` = 1.

## Configuration
- `UART_VERICI_FIFO_EN` defined: a FIFO of FIFO_DERINLIK words with show-ahead read.
  - `doluluk_o` ranges 0 … FIFO_DERINLIK.
- Not defined: a single holding register.
  - `veri_hazir_o` is high while the register is empty.
  - The register frees when its word moves into the shift register, so one word is buffered while another is being sent.
  - `doluluk_o` is 0 or 1.
- Latency and frame behaviour are identical in both builds.

## Structure
- Shared package `uart_paket`:
  - FSM state encodings;
  - `veri_bit_i` / `parite_i` encodings;
  - `HIGH` / `LOW` constants.
- Sub-module `uart_verici_fifo`: synchronous FIFO with count, show-ahead data, push/pop. Instantiated only under `UART_VERICI_FIFO_EN`.

## Test plan
- Reset, then accept 0xA5 with div = 4, 8N1 → `tx_o` reads 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks. `bitti_o` pulses at clock 40.
- Accept 0x1F with div = 3, 5 bits, odd parity, 2 stop → frame 0,1,1,1,1,1,0,1,1. Parity bit is 0; frame length 27 clocks.
- Build with FIFO, FIFO_DERINLIK = 4, `tx_en_i` = 0; push 6 words → `veri_hazir_o` drops after 4 words; `doluluk_o` = 4. Then set `tx_en_i` = 1 → 4 frames back-to-back with no idle clocks.
- div = 0 with 0x00 at 8N1 → every bit is 1 clock; frame length 10 clocks.
- Assert `rst_i` in the middle of VERI → `tx_o` = 1 and `mesgul_o` = 0 immediately; buffer empty. After release, the next accepted word sends a clean frame.
- Drop `tx_en_i` during VERI while a second word is queued → the first frame completes; the line stays idle until `tx_en_i` returns high.
